// File: rtl/sca_seq_pkg.sv
// Shared opcodes, FSM state encodings and status byte layout for the SAKURA-G command sequencer.
package sca_seq_pkg;

  localparam logic [7:0] OP_LDKEY  = 8'h01;
  localparam logic [7:0] OP_LDTXT  = 8'h02;
  localparam logic [7:0] OP_GO     = 8'h10;
  localparam logic [7:0] OP_RDRES  = 8'h20;
  localparam logic [7:0] OP_RDSTAT = 8'h30;
  localparam logic [7:0] OP_CLRERR = 8'h3F;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t LOAD = 3'd1;
  localparam state_t ARM  = 3'd2;
  localparam state_t RUN  = 3'd3;
  localparam state_t READ = 3'd4;

  localparam int ST_ERR  = 7;
  localparam int ST_SEEN = 6;
  localparam int ST_BUSY = 5;

  function automatic logic [7:0] status_byte(input logic err, input logic seen, input logic busy);
    logic [7:0] v;
    v          = '0;
    v[ST_ERR]  = err;
    v[ST_SEEN] = seen;
    v[ST_BUSY] = busy;
    return v;
  endfunction

endpackage

// File: rtl/sca_byte_shifter.sv
// Operand register that loads in parallel or shifts one byte in at the LSB end, MSB byte first.
module sca_byte_shifter
  import sca_seq_pkg::*;
#(
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [7:0]        din,
  input  logic [DATA_W-1:0] pin,
  output logic [DATA_W-1:0] pout
);

  // Parallel load wins over shift; DATA_W must be at least 16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pout <= '0;
    end else if (load) begin
      pout <= pin;
    end else if (shift) begin
      pout <= {pout[DATA_W-9:0], din};
    end
  end

endmodule

// File: rtl/sca_cmd_sequencer.sv
// Host byte-command sequencer: operand loading, core start/trigger, busy supervision with timeout, readback.
module sca_cmd_sequencer
  import sca_seq_pkg::*;
#(
  parameter int DATA_W   = 256,
  parameter int TMO_CYC  = 1048576,
  parameter int TRIG_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hwe,
  input  logic [7:0]        hdin,
  output logic              wrdy_n,
  input  logic              hre,
  output logic [7:0]        hdout,
  output logic              rrdy_n,
  output logic [DATA_W-1:0] key,
  output logic [DATA_W-1:0] text,
  output logic              start,
  input  logic              busy,
  input  logic [DATA_W-1:0] result,
  output logic              trig,
  output logic              err
);

  localparam int NB   = DATA_W / 8;
  localparam int BCW  = $clog2(NB + 1);
  localparam int TMOW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam int TRW  = $clog2(TRIG_LEN + 1);

  state_t              state;
  logic                tgt_text;
  logic [BCW-1:0]      bcnt;
  logic [BCW-1:0]      rlen;
  logic [TMOW-1:0]     tmo;
  logic [TRW-1:0]      trig_cnt;
  logic                seen;
  logic                busy_q;
  logic                err_q;
  logic [DATA_W-1:0]   res_q;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rd_pin;
  logic                wr_ok;
  logic                rd_ok;
  logic                rd_load;

  assign wr_ok   = hwe && (state == IDLE || state == LOAD);
  assign rd_ok   = hre && (state == READ);
  assign rd_load = wr_ok && (state == IDLE) && (hdin == OP_RDRES || hdin == OP_RDSTAT);
  assign rd_pin  = (hdin == OP_RDSTAT) ? {status_byte(err_q, seen, busy), {(DATA_W-8){1'b0}}} : res_q;

  sca_byte_shifter #(.DATA_W(DATA_W)) u_key (
    .clk(clk), .rst_n(rst_n), .load(1'b0),
    .shift(wr_ok && state == LOAD && !tgt_text),
    .din(hdin), .pin('0), .pout(key)
  );

  sca_byte_shifter #(.DATA_W(DATA_W)) u_text (
    .clk(clk), .rst_n(rst_n), .load(1'b0),
    .shift(wr_ok && state == LOAD && tgt_text),
    .din(hdin), .pin('0), .pout(text)
  );

  // Readout word is shifted with zeros so it empties itself after the last byte.
  sca_byte_shifter #(.DATA_W(DATA_W)) u_rd (
    .clk(clk), .rst_n(rst_n), .load(rd_load), .shift(rd_ok),
    .din(8'h00), .pin(rd_pin), .pout(rd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tgt_text <= 1'b0;
      bcnt     <= '0;
      rlen     <= '0;
      tmo      <= '0;
      trig_cnt <= '0;
      seen     <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      res_q    <= '0;
    end else begin
      busy_q <= busy;
      if (trig_cnt != '0) trig_cnt <= trig_cnt - 1'b1;
      case (state)
        IDLE: begin
          if (hwe) begin
            case (hdin)
              OP_LDKEY:  begin state <= LOAD; tgt_text <= 1'b0; bcnt <= '0; end
              OP_LDTXT:  begin state <= LOAD; tgt_text <= 1'b1; bcnt <= '0; end
              OP_GO:     begin state <= ARM; trig_cnt <= TRW'(TRIG_LEN); end
              OP_RDRES:  begin state <= READ; bcnt <= '0; rlen <= BCW'(NB); end
              OP_RDSTAT: begin state <= READ; bcnt <= '0; rlen <= BCW'(1); end
              OP_CLRERR: err_q <= 1'b0;
              default:   err_q <= 1'b1;
            endcase
          end
        end
        LOAD: begin
          if (hwe) begin
            bcnt <= bcnt + 1'b1;
            if (bcnt == BCW'(NB - 1)) state <= IDLE;
          end
        end
        ARM: begin
          tmo   <= '0;
          seen  <= busy;
          state <= RUN;
        end
        // A completed busy pulse takes priority over a timeout in the same cycle.
        RUN: begin
          tmo <= tmo + 1'b1;
          if (busy) seen <= 1'b1;
          if (seen && busy_q && !busy) begin
            res_q <= result;
            state <= IDLE;
          end else if (tmo == TMOW'(TMO_CYC - 1)) begin
            err_q <= 1'b1;
            state <= IDLE;
          end
        end
        READ: begin
          if (hre) begin
            bcnt <= bcnt + 1'b1;
            if (bcnt == rlen - 1'b1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wrdy_n = !(state == IDLE || state == LOAD);
  assign rrdy_n = (state != READ);
  assign hdout  = rd_word[DATA_W-1 -: 8];
  assign start  = (state == ARM);
  assign trig   = (trig_cnt != '0);
  assign err    = err_q;

endmodule

// File: tb/tb_sca_cmd_sequencer.sv
// Directed self-checking bench for sca_cmd_sequencer at DATA_W=32, TMO_CYC=64, TRIG_LEN=16.
module tb_sca_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hwe;
  logic [7:0]  hdin;
  logic        wrdy_n;
  logic        hre;
  logic [7:0]  hdout;
  logic        rrdy_n;
  logic [31:0] key;
  logic [31:0] text;
  logic        start;
  logic        busy;
  logic [31:0] result;
  logic        trig;
  logic        err;

  int tests_run    = 0;
  int tests_failed = 0;

  sca_cmd_sequencer #(.DATA_W(32), .TMO_CYC(64), .TRIG_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .hwe(hwe), .hdin(hdin), .wrdy_n(wrdy_n),
    .hre(hre), .hdout(hdout), .rrdy_n(rrdy_n), .key(key), .text(text),
    .start(start), .busy(busy), .result(result), .trig(trig), .err(err)
  );

  always #5 clk = ~clk;

  // Both strobes are one cycle wide and launched on the falling edge.
  task automatic wr_byte(input logic [7:0] b);
    hwe  = 1'b1;
    hdin = b;
    @(negedge clk);
    hwe  = 1'b0;
  endtask

  task automatic rd_byte(output logic [7:0] b);
    b   = hdout;
    hre = 1'b1;
    @(negedge clk);
    hre = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; hwe = 1'b0; hdin = 8'h00; hre = 1'b0; busy = 1'b0; result = '0;
    repeat (2) @(negedge clk);
    tests_run++; if (key !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_key: got %h expected %h", key, 32'h0); end
    tests_run++; if (wrdy_n !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wrdy_n: got %b expected 0", wrdy_n); end
    tests_run++; if (rrdy_n !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_rrdy_n: got %b expected 1", rrdy_n); end
    tests_run++; if ({start, trig, err, hdout} !== 11'h0) begin tests_failed++; $display("[TB] FAIL reset_outs: got start=%b trig=%b err=%b hdout=%h expected all 0", start, trig, err, hdout); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load;
    logic [7:0] seq [10];
    seq = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h02, 8'h01, 8'h23, 8'h45, 8'h67};
    for (int i = 0; i < 10; i++) wr_byte(seq[i]);
    tests_run++; if (key !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL load_key: got %h expected %h", key, 32'hDEADBEEF); end
    tests_run++; if (text !== 32'h01234567) begin tests_failed++; $display("[TB] FAIL load_text: got %h expected %h", text, 32'h01234567); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL load_err: got %b expected 0", err); end
  endtask

  task automatic test_go_result;
    int start_cnt;
    int trig_cnt;
    int first_start;
    logic [7:0] exp_b [4];
    logic [7:0] b;
    exp_b = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    start_cnt = 0; trig_cnt = 0; first_start = -1;
    result = 32'hCAFEF00D;
    wr_byte(8'h10);
    for (int i = 0; i < 40; i++) begin
      if (start) begin start_cnt++; if (first_start < 0) first_start = i; end
      if (trig) trig_cnt++;
      if (i == 1) begin
        tests_run++; if (wrdy_n !== 1'b1) begin tests_failed++; $display("[TB] FAIL run_wrdy_n: got %b expected 1", wrdy_n); end
      end
      if (i == 3) busy = 1'b1;
      if (i == 13) busy = 1'b0;
      @(negedge clk);
    end
    tests_run++; if (start_cnt !== 1 || first_start !== 0) begin tests_failed++; $display("[TB] FAIL start_pulse: got %0d cycles first at %0d expected 1 at 0", start_cnt, first_start); end
    tests_run++; if (trig_cnt !== 16) begin tests_failed++; $display("[TB] FAIL trig_len: got %0d expected 16", trig_cnt); end
    tests_run++; if (wrdy_n !== 1'b0) begin tests_failed++; $display("[TB] FAIL done_idle: got wrdy_n=%b expected 0", wrdy_n); end
    wr_byte(8'h20);
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (rrdy_n !== 1'b0 || hdout !== exp_b[i]) begin tests_failed++; $display("[TB] FAIL rdres_byte%0d: got rrdy_n=%b hdout=%h expected 0 %h", i, rrdy_n, hdout, exp_b[i]); end
      rd_byte(b);
    end
    tests_run++; if (rrdy_n !== 1'b1) begin tests_failed++; $display("[TB] FAIL rdres_end: got rrdy_n=%b expected 1", rrdy_n); end
  endtask

  task automatic test_timeout;
    logic [7:0] b;
    busy = 1'b0;
    wr_byte(8'h10);
    for (int n = 0; n < 70; n++) begin
      if (n == 64) begin
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL tmo_early: got err=%b expected 0", err); end
      end
      if (n == 65) begin
        tests_run++; if (err !== 1'b1 || wrdy_n !== 1'b0) begin tests_failed++; $display("[TB] FAIL tmo_err: got err=%b wrdy_n=%b expected 1 0", err, wrdy_n); end
      end
      @(negedge clk);
    end
    wr_byte(8'h30);
    tests_run++; if (rrdy_n !== 1'b0 || hdout !== 8'h80) begin tests_failed++; $display("[TB] FAIL stat_err: got rrdy_n=%b hdout=%h expected 0 80", rrdy_n, hdout); end
    rd_byte(b);
    tests_run++; if (rrdy_n !== 1'b1) begin tests_failed++; $display("[TB] FAIL stat_end: got rrdy_n=%b expected 1", rrdy_n); end
    wr_byte(8'h3F);
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL clrerr: got err=%b expected 0", err); end
    wr_byte(8'h30);
    tests_run++; if (hdout !== 8'h00) begin tests_failed++; $display("[TB] FAIL stat_clear: got %h expected 00", hdout); end
    rd_byte(b);
  endtask

  task automatic test_ignored;
    logic [7:0] h0;
    wr_byte(8'h55);
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("[TB] FAIL bad_op_err: got %b expected 1", err); end
    tests_run++; if (key !== 32'hDEADBEEF || text !== 32'h01234567) begin tests_failed++; $display("[TB] FAIL bad_op_regs: got %h %h expected deadbeef 01234567", key, text); end
    wr_byte(8'h3F);
    result = 32'h11111111;
    wr_byte(8'h10);
    busy = 1'b1;
    @(negedge clk);
    hwe = 1'b1; hdin = 8'h01;
    @(negedge clk);
    hdin = 8'hAA;
    @(negedge clk);
    hwe = 1'b0; busy = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (key !== 32'hDEADBEEF || err !== 1'b0 || wrdy_n !== 1'b0) begin tests_failed++; $display("[TB] FAIL hwe_in_run: got key=%h err=%b wrdy_n=%b expected deadbeef 0 0", key, err, wrdy_n); end
    h0 = hdout;
    hre = 1'b1;
    @(negedge clk);
    hre = 1'b0;
    @(negedge clk);
    tests_run++; if (hdout !== h0 || rrdy_n !== 1'b1 || wrdy_n !== 1'b0) begin tests_failed++; $display("[TB] FAIL hre_in_idle: got hdout=%h rrdy_n=%b wrdy_n=%b expected %h 1 0", hdout, rrdy_n, wrdy_n, h0); end
  endtask

  task automatic test_reset_mid_load;
    wr_byte(8'h01); wr_byte(8'h11); wr_byte(8'h22);
    rst_n = 1'b0;
    #1;
    tests_run++; if (key !== 32'h0 || text !== 32'h0) begin tests_failed++; $display("[TB] FAIL midload_regs: got %h %h expected 0 0", key, text); end
    tests_run++; if ({wrdy_n, rrdy_n, start, trig, err, hdout} !== 13'b0_1_0_0_0_00000000) begin tests_failed++; $display("[TB] FAIL midload_outs: got wrdy_n=%b rrdy_n=%b start=%b trig=%b err=%b hdout=%h", wrdy_n, rrdy_n, start, trig, err, hdout); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_byte(8'h01); wr_byte(8'hA1); wr_byte(8'hB2); wr_byte(8'hC3); wr_byte(8'hD4);
    tests_run++; if (key !== 32'hA1B2C3D4 || text !== 32'h0) begin tests_failed++; $display("[TB] FAIL reload_key: got %h %h expected a1b2c3d4 0", key, text); end
  endtask

  task automatic test_reset_mid_run;
    logic [7:0] b;
    result = 32'h99887766;
    wr_byte(8'h10);
    busy = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    busy = 1'b0;
    repeat (3) @(negedge clk);
    wr_byte(8'h20);
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (rrdy_n !== 1'b0 || hdout !== 8'h00) begin tests_failed++; $display("[TB] FAIL abort_byte%0d: got rrdy_n=%b hdout=%h expected 0 00", i, rrdy_n, hdout); end
      rd_byte(b);
    end
    tests_run++; if (rrdy_n !== 1'b1 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_end: got rrdy_n=%b err=%b expected 1 0", rrdy_n, err); end
  endtask

  initial begin
    test_reset;
    test_load;
    test_go_result;
    test_timeout;
    test_ignored;
    test_reset_mid_load;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
